// File: rtl/brg_frac.sv
// Fractional baud rate generator: rx_tick at baud*OVERSAMPLE, tx_tick every OVERSAMPLE rx_ticks.
// Period is cur_int or cur_int+1 cycles, chosen by a phase accumulator over cur_frac.
module brg_frac #(
    parameter int              INT_W      = 16,
    parameter int              FRAC_W     = 4,
    parameter int              OVERSAMPLE = 16,
    parameter logic [INT_W-1:0]  DEF_INT  = 16'd325,
    parameter logic [FRAC_W-1:0] DEF_FRAC = 4'd8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              rx_tick,
    output logic              tx_tick,
    output logic              busy
);
    localparam int CW   = INT_W + 1;
    localparam int OS_W = $clog2(OVERSAMPLE);

    logic [INT_W-1:0]  cur_int;
    logic [FRAC_W-1:0] cur_frac;
    logic [CW-1:0]     cnt;
    logic [FRAC_W-1:0] acc;
    logic              extra;
    logic [OS_W-1:0]   os_cnt;

    logic              valid;
    logic              run;
    logic [CW-1:0]     limit;
    logic              term;
    logic [FRAC_W:0]   acc_sum;

    assign valid   = (cur_int >= INT_W'(2));
    assign run     = enable & valid;
    // Extra cycle is owed when the previous tick's accumulator step carried out.
    assign limit   = {1'b0, cur_int} - CW'(1) + CW'(extra);
    assign term    = (cnt == limit);
    assign acc_sum = {1'b0, acc} + {1'b0, cur_frac};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_int  <= DEF_INT;
            cur_frac <= DEF_FRAC;
            cnt      <= '0;
            acc      <= '0;
            extra    <= 1'b0;
            os_cnt   <= '0;
            rx_tick  <= 1'b0;
            tx_tick  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            busy <= run;
            if (div_load) begin
                cur_int  <= div_int;
                cur_frac <= div_frac;
                cnt      <= '0;
                acc      <= '0;
                extra    <= 1'b0;
                os_cnt   <= '0;
                rx_tick  <= 1'b0;
                tx_tick  <= 1'b0;
            end else if (run) begin
                if (term) begin
                    cnt     <= '0;
                    acc     <= acc_sum[FRAC_W-1:0];
                    extra   <= acc_sum[FRAC_W];
                    os_cnt  <= os_cnt + OS_W'(1);
                    rx_tick <= 1'b1;
                    tx_tick <= (os_cnt == OS_W'(OVERSAMPLE - 1));
                end else begin
                    cnt     <= cnt + CW'(1);
                    rx_tick <= 1'b0;
                    tx_tick <= 1'b0;
                end
            end else begin
                // Stopped or invalid divisor: state holds so a restart resumes mid-period.
                rx_tick <= 1'b0;
                tx_tick <= 1'b0;
            end
        end
    end
endmodule
